// File: rtl/alu_pipe.sv
// alu_pipe: ALU with a registered output stage and valid/ready handshakes.
// Build option ALU_PIPE_MUL_EN enables the iterative shift-add multiplier (op 111).
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic             out_free;
  logic             accept;
  logic             is_mul;
  logic             mul_last;
  logic             mul_load;
  logic [WIDTH-1:0] mul_prod;

  logic [7:0]       op_dec;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ill;

  assign op_dec = 8'b1 << op;
  assign sum    = {1'b0, data1} + {1'b0, data2};
  assign diff   = {1'b0, data1} - {1'b0, data2};

  // diff[WIDTH] is the borrow, i.e. data1 < data2 unsigned
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ill   = 1'b0;
    unique case (1'b1)
      op_dec[0]: alu_res = data1;
      op_dec[1]: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      op_dec[2]: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
      end
      op_dec[3]: alu_res = data1 & data2;
      op_dec[4]: alu_res = data1 | data2;
      op_dec[5]: alu_res = data1 ^ data2;
      op_dec[6]: begin
        alu_res = {{(WIDTH-1){1'b0}},
                   $signed(data1) < $signed(data2)};
      end
      op_dec[7]: begin
`ifdef ALU_PIPE_MUL_EN
        alu_ill = 1'b0;
`else
        alu_ill = 1'b1;
`endif
      end
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [CW-1:0]    cnt;

  assign is_mul   = op_dec[7];
  assign acc_nx   = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (state == BUSY) && (cnt == CW'(WIDTH-1));
  assign mul_prod = (state == BUSY) ? acc_nx : acc;

  // one multiplier bit per BUSY cycle; acc keeps the product in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && is_mul) begin
      mcand  <= data1;
      mplier <= data2;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_last = 1'b0;
  assign mul_prod = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept && is_mul) begin
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (mul_last) begin
          state_nx = out_free ? IDLE : DONE;
        end
      end
      DONE: begin
        if (out_free) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    out_free = !out_valid || out_ready;
    in_ready = (state == IDLE) && out_free;
    accept   = in_valid && in_ready;
    mul_load = out_free &&
               (mul_last || (state == DONE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      zero      <= (alu_res == '0);
      carry     <= alu_carry;
      illegal   <= alu_ill;
    end else if (mul_load) begin
      out_valid <= 1'b1;
      result    <= mul_prod;
      zero      <= (mul_prod == '0);
      carry     <= 1'b0;
      illegal   <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  a_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=> out_valid && $stable(result)
  );

  a_busy: assert property (
    @(posedge clk) disable iff (!rst_n)
    state != IDLE |-> !in_ready
  );

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized and directed stimulus for alu_pipe.
// Expected results come from an arithmetic reference model via a scoreboard queue.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic [W-1:0] data1 = '0;
  logic [W-1:0] data2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         illegal;

  int n_assert = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  int cyc      = 0;
  bit rand_rdy = 1'b0;

  typedef struct {
    longint res;
    bit     z;
    bit     c;
    bit     ill;
    int     cyc;
    bit     chk_lat;
    int     lat;
  } exp_t;

  exp_t sb[$];
  exp_t push_e;
  exp_t mon_e;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .data1     (data1),
    .data2     (data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(string name, longint act, longint exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(int o, longint a, longint b);
    exp_t   e;
    longint m;
    longint sa;
    longint sb2;
    m = longint'(1) << W;
    e.res = 0;
    e.c = 1'b0;
    e.ill = 1'b0;
    e.cyc = 0;
    e.chk_lat = 1'b0;
    e.lat = 1;
    case (o)
      0: e.res = a;
      1: begin
        e.res = (a + b) % m;
        e.c = (a + b) >= m;
      end
      2: begin
        e.res = (a - b + m) % m;
        e.c = a < b;
      end
      3: e.res = a & b;
      4: e.res = a | b;
      5: e.res = a ^ b;
      6: begin
        sa  = (a >= m / 2) ? a - m : a;
        sb2 = (b >= m / 2) ? b - m : b;
        e.res = (sa < sb2) ? 1 : 0;
      end
      default: begin
`ifdef ALU_PIPE_MUL_EN
        e.res = (a * b) % m;
        e.lat = W + 1;
`else
        e.ill = 1'b1;
`endif
      end
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      push_e = model(int'(op), longint'(data1), longint'(data2));
      push_e.cyc = cyc;
      push_e.chk_lat = !rand_rdy && out_ready;
      sb.push_back(push_e);
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_pop++;
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%0h, want none", result);
      end else begin
        mon_e = sb.pop_front();
        check("result", longint'(result), mon_e.res);
        check("flags_zci", longint'({zero, carry, illegal}),
              longint'({mon_e.z, mon_e.c, mon_e.ill}));
        if (mon_e.chk_lat) check("latency", cyc - mon_e.cyc, mon_e.lat);
      end
    end
  end

  task automatic send(int o, int a, int b);
    bit ok;
    op = o[2:0];
    data1 = a[W-1:0];
    data2 = b[W-1:0];
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    n_assert++;
    n_fail++;
    $display("FAIL send_timeout: op %0d not accepted in 60 cycles", o);
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bit seen;

    repeat (3) @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_result", longint'(result), 0);
    check("rst_flags", longint'({zero, carry, illegal}), 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;

    p0 = n_pop;
    send(1, 'h12, 'h34);
    send(2, 'h05, 'h07);
    send(3, 'hF0, 'h3C);
    idle(3);
    check("b2b_pops", n_pop - p0, 3);

    send(1, 'hFF, 'h01);
    send(0, 'hA5, 'h3C);
    send(6, 'h80, 'h7F);
    idle(3);

    out_ready = 1'b0;
    send(1, 3, 4);
    op = 3'd5;
    data1 = 8'h55;
    data2 = 8'h0F;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", longint'(out_valid), 1);
      check("hold_result", longint'(result), 7);
      check("hold_in_ready", longint'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("accept_on_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    idle(3);

`ifdef ALU_PIPE_MUL_EN
    send(7, 13, 11);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mul_busy_ready", longint'(in_ready), 0);
    end
    @(negedge clk);
    check("mul_out_valid", longint'(out_valid), 1);
    @(posedge clk);
    #1;
    send(7, 'hFF, 'h02);
    idle(12);
    send(7, 9, 9);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
`else
    send(7, 5, 6);
    idle(3);
`endif
    in_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst_async_valid", longint'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_in_ready", longint'(in_ready), 1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", longint'(seen), 0);
    @(posedge clk);
    #1;
    send(1, 1, 1);
    idle(3);

    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(int'($urandom_range(0, 7)), int'($urandom), int'($urandom));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_empty", longint'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
